// File: rtl/alu_pkg.sv
// Shared opcode, state and sizing definitions for the multi-cycle ALU sequencer.
package alu_pkg;

  localparam int DEFAULT_SIZE = 4;

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_NEG  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PASS1  = 2'd1,
    PASS2  = 2'd2,
    DONE_S = 2'd3
  } state_t;

  // SUB and NEG need an inversion pass before the adder pass.
  function automatic logic is_two_pass(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_NEG);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_not.sv
// Inversion stage of the ALU datapath; purely combinational bitwise NOT.
module not_mod #(
  parameter int SIZE = 4
) (
  input  logic [SIZE-1:0] a,
  output logic [SIZE-1:0] y
);

  assign y = ~a;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: START/BUSY handshake, operand latching, one or two
// datapath passes, registered result with carry/zero flags and a DONE pulse.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] y,
  output logic            cout,
  output logic            zero
);

  localparam logic [SIZE:0] ONE = (SIZE+1)'(1);

  state_t          state;
  logic [2:0]      op_r;
  logic [SIZE-1:0] a_r;
  logic [SIZE-1:0] b_r;
  logic [SIZE-1:0] tmp;

  logic            accept;
  logic [SIZE-1:0] not_in;
  logic [SIZE-1:0] not_out;
  logic [SIZE:0]   add_sum;
  logic [SIZE:0]   pass2_sum;
  logic [SIZE-1:0] p1_y;
  logic            p1_c;

  assign accept = start && ((state == IDLE) || (state == DONE_S));

  // SUB inverts the subtrahend; every other op that uses the inverter wants A.
  assign not_in = (op_r == OP_SUB) ? b_r : a_r;

  not_mod #(.SIZE(SIZE)) u_not (
    .a (not_in),
    .y (not_out)
  );

  assign add_sum   = {1'b0, a_r} + {1'b0, b_r};
  assign pass2_sum = (op_r == OP_SUB) ? ({1'b0, a_r} + {1'b0, tmp} + ONE)
                                      : ({1'b0, tmp} + ONE);

  always_comb begin
    p1_y = '0;
    p1_c = 1'b0;
    case (op_r)
      OP_NOT:  p1_y = not_out;
      OP_AND:  p1_y = a_r & b_r;
      OP_OR:   p1_y = a_r | b_r;
      OP_XOR:  p1_y = a_r ^ b_r;
      OP_ADD:  {p1_c, p1_y} = add_sum;
      OP_PASS: p1_y = a_r;
      default: p1_y = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= PASS1;
            busy  <= 1'b1;
          end
        end
        PASS1: begin
          if (is_two_pass(op_r)) begin
            state <= PASS2;
          end else begin
            state <= DONE_S;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        PASS2: begin
          state <= DONE_S;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE_S: begin
          if (start) begin
            state <= PASS1;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result registers only move on the edge that enters DONE_S.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r <= OP_NOT;
      a_r  <= '0;
      b_r  <= '0;
      tmp  <= '0;
      y    <= '0;
      cout <= 1'b0;
      zero <= 1'b0;
    end else begin
      if (accept) begin
        op_r <= op;
        a_r  <= a;
        b_r  <= b;
      end
      case (state)
        PASS1: begin
          if (is_two_pass(op_r)) begin
            tmp <= not_out;
          end else begin
            y    <= p1_y;
            cout <= p1_c;
            zero <= (p1_y == '0);
          end
        end
        PASS2: begin
          y    <= pass2_sum[SIZE-1:0];
          cout <= pass2_sum[SIZE];
          zero <= (pass2_sum[SIZE-1:0] == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed cases, handshake corner cases
// and randomized commands against an arithmetic reference model.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic       busy;
  logic       done;
  logic [3:0] y;
  logic       cout;
  logic       zero;

  int vectors = 0;
  int miscompares = 0;

  alu_seq_ctrl #(.SIZE(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .cout  (cout),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  // Result as {cout, y} from plain integer arithmetic on 4-bit values.
  function automatic logic [4:0] ref_model(input logic [2:0] o, input int ua, input int ub);
    int r;
    logic c;
    r = 0;
    c = 1'b0;
    case (o)
      3'd0: r = 15 - ua;
      3'd1: r = ua & ub;
      3'd2: r = ua | ub;
      3'd3: r = ua ^ ub;
      3'd4: begin r = ua + ub; c = (r > 15); r = r % 16; end
      3'd5: begin c = (ua >= ub); r = (ua - ub + 16) % 16; end
      3'd6: begin c = (ua == 0); r = (16 - ua) % 16; end
      default: r = ua;
    endcase
    return {c, 4'(r)};
  endfunction

  function automatic int ref_latency(input logic [2:0] o);
    return (o == 3'd5 || o == 3'd6) ? 2 : 1;
  endfunction

  // Drives one command, scrambles the inputs after acceptance, waits for DONE.
  task automatic issue(input logic [2:0] o, input logic [3:0] ia, input logic [3:0] ib,
                       output int lat, output logic bsy0, output logic [3:0] yo,
                       output logic co, output logic zo, output logic bsy_done);
    @(negedge clk);
    start = 1'b1; op = o; a = ia; b = ib;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = 4'($urandom); b = 4'($urandom);
    bsy0 = busy;
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    yo = y; co = cout; zo = zero; bsy_done = busy;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 3'd4; a = 4'h5; b = 4'h6;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, y, cout, zero} !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b y=%h cout=%b zero=%b, want all 0",
               busy, done, y, cout, zero);
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_no_latch: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [2:0] ops [10] = '{3'd4, 3'd5, 3'd5, 3'd0, 3'd6, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3};
    logic [3:0] as  [10] = '{4'hF, 4'h5, 4'h3, 4'hA, 4'h1, 4'h0, 4'h9, 4'hC, 4'hC, 4'hF};
    logic [3:0] bs  [10] = '{4'h1, 4'h3, 4'h5, 4'h7, 4'h7, 4'h7, 4'h2, 4'hA, 4'h3, 4'h5};
    logic [3:0] ys  [10] = '{4'h0, 4'h2, 4'hE, 4'h5, 4'hF, 4'h0, 4'h9, 4'h8, 4'hF, 4'hA};
    logic       cs  [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int         ls  [10] = '{1, 2, 2, 1, 2, 2, 1, 1, 1, 1};
    int lat;
    logic bsy0, co, zo, bd;
    logic [3:0] yo;
    for (int i = 0; i < 10; i++) begin
      issue(ops[i], as[i], bs[i], lat, bsy0, yo, co, zo, bd);
      vectors++;
      if (lat !== ls[i] || bsy0 !== 1'b1 || bd !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL dir_handshake[%0d]: got lat=%0d busy_after_accept=%b busy_at_done=%b, want lat=%0d 1 0",
                 i, lat, bsy0, bd, ls[i]);
      end
      vectors++;
      if (yo !== ys[i] || co !== cs[i] || zo !== (ys[i] == 4'h0)) begin
        miscompares++;
        $display("[TB] FAIL dir_result[%0d]: got y=%h cout=%b zero=%b, want y=%h cout=%b zero=%b",
                 i, yo, co, zo, ys[i], cs[i], ys[i] == 4'h0);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || y !== ys[i]) begin
        miscompares++;
        $display("[TB] FAIL dir_pulse[%0d]: got done=%b y=%h, want done=0 y=%h", i, done, y, ys[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic bsy0, co, zo, bd;
    logic [3:0] yo, ra, rb;
    logic [2:0] ro;
    logic [4:0] exp;
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom);
      ra = 4'($urandom);
      rb = 4'($urandom);
      exp = ref_model(ro, int'(ra), int'(rb));
      issue(ro, ra, rb, lat, bsy0, yo, co, zo, bd);
      vectors++;
      if (lat !== ref_latency(ro) || {co, yo} !== exp || zo !== (exp[3:0] == 4'h0) || bd !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rand[%0d] op=%0d a=%h b=%h: got lat=%0d cout=%b y=%h zero=%b busy=%b, want lat=%0d cout=%b y=%h zero=%b busy=0",
                 i, ro, ra, rb, lat, co, yo, zo, bd, ref_latency(ro), exp[4], exp[3:0], exp[3:0] == 4'h0);
      end
    end
  endtask

  task automatic test_ignore_busy();
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 4'h5; b = 4'h3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ignore_pass2_state: got busy=%b done=%b, want 1 0", busy, done);
    end
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 4'hF; b = 4'hF;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (done !== 1'b1 || y !== 4'h2 || cout !== 1'b1 || zero !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ignore_result: got done=%b y=%h cout=%b zero=%b, want 1 2 1 0",
               done, y, cout, zero);
    end
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || y !== 4'h2) begin
      miscompares++;
      $display("[TB] FAIL ignore_no_queue: got busy=%b done=%b y=%h, want 0 0 2", busy, done, y);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 4'h2; b = 4'h3;
    @(posedge clk); #1;
    op = 3'd5; a = 4'h9; b = 4'h2;
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b1 || y !== 4'h5 || cout !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_first: got done=%b y=%h cout=%b, want 1 5 0", done, y, cout);
    end
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_accept: got busy=%b done=%b, want 1 0", busy, done);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b1 || y !== 4'h7 || cout !== 1'b1 || zero !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got done=%b y=%h cout=%b zero=%b, want 1 7 1 0",
               done, y, cout, zero);
    end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    int lat;
    logic bsy0, co, zo, bd;
    logic [3:0] yo;
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 4'h7; b = 4'h2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || y !== 4'h0 || cout !== 1'b0 || zero !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_async: got busy=%b done=%b y=%h cout=%b zero=%b, want all 0",
               busy, done, y, cout, zero);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1 || y !== 4'h0) seen_done++;
    end
    vectors++;
    if (seen_done !== 0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_discard: got %0d cycles with done/busy/y activity, want 0", seen_done);
    end
    issue(3'd4, 4'h2, 4'h3, lat, bsy0, yo, co, zo, bd);
    vectors++;
    if (lat !== 1 || yo !== 4'h5 || co !== 1'b0 || zo !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_recover: got lat=%0d y=%h cout=%b zero=%b, want 1 5 0 0",
               lat, yo, co, zo);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
